// File: rtl/seq_pattern_detector.sv
// Runtime-programmable Mealy serial-pattern detector with input qualifier,
// registered detect pulse and saturating detection counter.
module seq_pattern_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 DEF_LEN     = 5,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b10110,
    parameter logic               DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_seq,
    input  logic               cfg_we,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               det_out,
    output logic               det_reg,
    output logic [CNT_W-1:0]   det_cnt
    ,
    output logic               cfg_err
);

    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_reg_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] window, mask;
    logic [LEN_W-1:0]   len_m1;
    logic               cfg_ok, match;

    assign len_m1 = len_q - LEN_W'(1);
    assign window = {hist_q[MAX_LEN-2:0], in_seq};
    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    // Only the low len_q bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (LEN_W'(i) < len_q);
    end

    assign match   = in_valid && (fill_q >= len_m1) && (((window ^ pat_q) & mask) == '0);
    assign det_out = match && rst && !cfg_we;

    always_comb begin
        len_d  = len_q;
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        err_d  = 1'b0;
        cnt_d  = cnt_q;
        if (cfg_we) begin
            if (cfg_ok) begin
                len_d  = cfg_len;
                pat_d  = cfg_pattern;
                ovl_d  = cfg_overlap;
                hist_d = '0;
                fill_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = window;
            // Non-overlapping mode needs a full fresh pattern after each hit.
            if (match && !ovl_q)
                fill_d = '0;
            else if (fill_q < len_m1)
                fill_d = fill_q + LEN_W'(1);
            else
                fill_d = len_m1;
        end
        if (cnt_clr)
            cnt_d = '0;
        else if (det_out && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q     <= LEN_W'(DEF_LEN);
            pat_q     <= DEF_PATTERN;
            ovl_q     <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            det_reg_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            len_q     <= len_d;
            pat_q     <= pat_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            det_reg_q <= det_out;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign det_reg = det_reg_q;
    assign det_cnt = cnt_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: vector tables, hand sequences
// and a randomized run against a queue-based reference model.
module tb_seq_pattern_detector;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_seq, cfg_we, cfg_overlap, cnt_clr;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_pattern;
    logic        det_out, det_reg, cfg_err;
    logic [15:0] det_cnt;
    logic        det_out2, det_reg2, cfg_err2;
    logic [1:0]  det_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_pattern_detector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
        .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .det_out(det_out), .det_reg(det_reg), .det_cnt(det_cnt), .cfg_err(cfg_err)
    );

    seq_pattern_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
        .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .det_out(det_out2), .det_reg(det_reg2), .det_cnt(det_cnt2), .cfg_err(cfg_err2)
    );

    // Reference model: the stream since the last discard, kept as a bit queue.
    bit       q[$];
    int       mlen;
    bit [7:0] mpat;
    bit       movl;
    int       mcnt, mcnt2;
    bit       mdreg, merr, mdet;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_det();
        bit w[$];
        if (!rst || cfg_we || !in_valid) return 1'b0;
        w = q;
        w.push_back(in_seq);
        if (w.size() < mlen) return 1'b0;
        for (int k = 0; k < mlen; k++)
            if (w[w.size() - mlen + k] != mpat[mlen - 1 - k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        mlen = 5; mpat = 8'b10110; movl = 1'b1;
        mcnt = 0; mcnt2 = 0; mdreg = 1'b0; merr = 1'b0;
    endtask

    task automatic model_clock();
        if (!rst) begin
            model_reset();
            return;
        end
        mdreg = mdet;
        merr  = cfg_we && (cfg_len == 0 || cfg_len > 8);
        if (cnt_clr) begin
            mcnt = 0; mcnt2 = 0;
        end else if (mdet) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt2 < 3) mcnt2++;
        end
        if (cfg_we) begin
            if (!merr) begin
                mlen = int'(cfg_len); mpat = cfg_pattern; movl = cfg_overlap;
                q.delete();
            end
        end else if (in_valid) begin
            q.push_back(in_seq);
            if (mdet && !movl) q.delete();
            while (q.size() > 8) void'(q.pop_front());
        end
    endtask

    // Called at posedge+1 with inputs already applied.
    task automatic tick();
        #1;
        mdet = model_det();
        chk("det_out", int'(det_out), int'(mdet));
        chk("det_out2", int'(det_out2), int'(mdet));
        @(posedge clk);
        model_clock();
        #1;
        chk("det_reg", int'(det_reg), int'(mdreg));
        chk("det_cnt", int'(det_cnt), mcnt);
        chk("det_cnt2", int'(det_cnt2), mcnt2);
        chk("cfg_err", int'(cfg_err), int'(merr));
    endtask

    task automatic idle();
        rst = 1'b1; in_valid = 1'b0; in_seq = 1'b0; cfg_we = 1'b0;
        cfg_len = '0; cfg_pattern = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic send(input bit s);
        idle(); in_valid = 1'b1; in_seq = s; tick();
    endtask

    task automatic cfg(input logic [3:0] l, input logic [7:0] p, input bit o);
        idle(); cfg_we = 1'b1; cfg_len = l; cfg_pattern = p; cfg_overlap = o; tick();
    endtask

    task automatic clr();
        idle(); cnt_clr = 1'b1; tick();
    endtask

    typedef struct {
        bit s;
        bit exp_det;
    } vec_t;

    vec_t t1[8];
    vec_t t2[8];

    initial begin
        bit [7:0] bits8;
        bits8 = 8'b10110110;
        for (int i = 0; i < 8; i++) begin
            t1[i].s = bits8[7 - i];
            t2[i].s = bits8[7 - i];
            t1[i].exp_det = (i == 4) || (i == 7);
            t2[i].exp_det = (i == 4);
        end

        model_reset();
        idle(); rst = 1'b0;
        @(posedge clk); #1;
        tick();
        chk("reset det_cnt", int'(det_cnt), 0);
        chk("reset det_reg", int'(det_reg), 0);
        chk("reset cfg_err", int'(cfg_err), 0);

        // T1: defaults, overlapping
        for (int i = 0; i < 8; i++) begin
            idle(); in_valid = 1'b1; in_seq = t1[i].s;
            #1 chk("T1 det_out", int'(det_out), int'(t1[i].exp_det));
            tick();
            chk("T1 det_reg", int'(det_reg), int'(t1[i].exp_det));
        end
        chk("T1 det_cnt", int'(det_cnt), 2);

        // T2: non-overlapping
        cfg(4'd5, 8'b10110, 1'b0);
        clr();
        for (int i = 0; i < 8; i++) begin
            idle(); in_valid = 1'b1; in_seq = t2[i].s;
            #1 chk("T2 det_out", int'(det_out), int'(t2[i].exp_det));
            tick();
        end
        chk("T2 det_cnt", int'(det_cnt), 1);

        // T3: len 6 with a gap between two patterns
        cfg(4'd6, 8'b111010, 1'b1);
        clr();
        for (int r = 0; r < 2; r++) begin
            bits8 = 8'b00111010;
            for (int i = 5; i >= 0; i--) send(bits8[i]);
            if (r == 0) begin
                chk("T3 first det_reg", int'(det_reg), 1);
                for (int g = 0; g < 3; g++) begin idle(); tick(); end
            end
        end
        chk("T3 det_cnt", int'(det_cnt), 2);

        // T4: reset mid-pattern
        send(1); send(0); send(1);
        idle(); rst = 1'b0; tick();
        chk("T4 det_cnt after rst", int'(det_cnt), 0);
        send(1); send(0);
        chk("T4 no detect", int'(det_cnt), 0);
        send(1); send(0); send(1); send(1); send(0);
        chk("T4 one detect", int'(det_cnt), 1);

        // T5: rejected write, then cfg_we on the final pattern bit
        idle(); cfg_we = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'hFF; in_valid = 1'b1; in_seq = 1'b1;
        tick();
        chk("T5 cfg_err pulse", int'(cfg_err), 1);
        idle(); tick();
        chk("T5 cfg_err clears", int'(cfg_err), 0);
        cfg(4'd9, 8'hFF, 1'b0);
        clr();
        send(1); send(0); send(1); send(1); send(0);
        chk("T5 config unchanged", int'(det_cnt), 1);
        send(1); send(0); send(1); send(1);
        idle(); cfg_we = 1'b1; cfg_len = 4'd5; cfg_pattern = 8'b10110; cfg_overlap = 1'b1;
        in_valid = 1'b1; in_seq = 1'b0;
        #1 chk("T5 det_out blocked", int'(det_out), 0);
        tick();
        send(1); send(1); send(0);
        chk("T5 hist cleared", int'(det_cnt), 1);

        // T6: continuous matches saturate the narrow counter
        cfg(4'd1, 8'b1, 1'b1);
        clr();
        for (int i = 0; i < 5; i++) send(1);
        chk("T6 saturate", int'(det_cnt2), 3);
        chk("T6 wide count", int'(det_cnt), 5);
        idle(); in_valid = 1'b1; in_seq = 1'b1; cnt_clr = 1'b1; tick();
        chk("T6 clr beats detect", int'(det_cnt2), 0);

        // Randomized stream with occasional reconfiguration
        for (int n = 0; n < 1500; n++) begin
            int r;
            idle();
            r = int'($urandom_range(0, 99));
            in_valid = ($urandom_range(0, 3) != 0);
            in_seq   = 1'($urandom);
            cnt_clr  = (r < 2);
            if (r >= 95) begin
                cfg_we      = 1'b1;
                cfg_len     = (r == 99) ? 4'($urandom) : 4'($urandom_range(1, 4));
                cfg_pattern = 8'($urandom);
                cfg_overlap = 1'($urandom);
            end
            if (r == 2 && $urandom_range(0, 3) == 0) rst = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
